// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures as short, long or double presses.
// While a long press is held it also emits periodic auto-repeat ticks.
module button_press_classifier #(
    parameter int LONG_CYCLES   = 8,
    parameter int GAP_CYCLES    = 5,
    parameter int REPEAT_CYCLES = 4,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    input  logic db_tick,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_tick,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HELD
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            repeat_tick  <= 1'b0;
        end else begin
            // NOTE: pulses default low here so every branch below only raises the one it owns.
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            repeat_tick  <= 1'b0;

            case (state)
                IDLE: begin
                    if (db_tick) begin
                        state <= PRESS1;
                        cnt   <= CNT_ONE;
                    end
                end

                PRESS1: begin
                    if (!db_level) begin
                        state <= WAIT2;
                        cnt   <= CNT_ONE;
                    end else if (cnt == LONG_LAST) begin
                        state      <= LONG_HELD;
                        cnt        <= CNT_ONE;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                WAIT2: begin
                    // A second tick beats the gap timeout when both land together.
                    if (db_tick) begin
                        state        <= PRESS2;
                        double_press <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        state       <= IDLE;
                        short_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                PRESS2: begin
                    if (!db_level) begin
                        state <= IDLE;
                    end
                end

                LONG_HELD: begin
                    if (!db_level) begin
                        state <= IDLE;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt         <= CNT_ONE;
                        repeat_tick <= REPEAT_EN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench: a gesture-level model predicts pulse times and busy,
// a negedge monitor compares two instances (repeat enabled and disabled).
module tb_button_press_classifier;

    localparam int LONG = 8;
    localparam int GAP  = 5;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic reset;
    logic db_level;
    logic db_tick;
    logic sp1, lp1, dp1, rt1, bz1;
    logic sp0, lp0, dp0, rt0, bz0;

    always #5 clk = ~clk;

    button_press_classifier #(
        .LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b1), .CNT_W(8)
    ) dut_rep (
        .clk(clk), .reset(reset), .db_level(db_level), .db_tick(db_tick),
        .short_press(sp1), .long_press(lp1), .double_press(dp1), .repeat_tick(rt1), .busy(bz1)
    );

    button_press_classifier #(
        .LONG_CYCLES(LONG), .GAP_CYCLES(GAP), .REPEAT_CYCLES(REP), .REPEAT_EN(1'b0), .CNT_W(8)
    ) dut_norep (
        .clk(clk), .reset(reset), .db_level(db_level), .db_tick(db_tick),
        .short_press(sp0), .long_press(lp0), .double_press(dp0), .repeat_tick(rt0), .busy(bz0)
    );

    typedef enum int {K_SHORT, K_LONG, K_DOUBLE, K_REPEAT, K_NONE} kind_e;
    typedef struct {
        int    t;
        kind_e k;
    } ev_t;

    ev_t evq[2][$];
    bit  busy_q[$];
    int  cyc     = 0;
    int  checks  = 0;
    int  errors  = 0;
    bit  running = 1'b0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Index 1 is the repeat-enabled instance; repeats are never expected on index 0.
    function automatic void expect_ev(int t, kind_e k);
        ev_t e;
        e.t = t;
        e.k = k;
        evq[1].push_back(e);
        if (k != K_REPEAT) evq[0].push_back(e);
    endfunction

    task automatic mon(int i, logic sp, logic lp, logic dp, logic rt, logic bz, bit has_busy, bit bz_exp);
        kind_e k;
        ev_t   e;
        while (evq[i].size() > 0 && evq[i][0].t < cyc) begin
            e = evq[i].pop_front();
            check($sformatf("missed_pulse_dut%0d_t%0d", i, e.t), int'(K_NONE), int'(e.k));
        end
        if (sp || lp || dp || rt) begin
            check($sformatf("onehot_dut%0d", i), $countones({sp, lp, dp, rt}), 1);
            k = sp ? K_SHORT : lp ? K_LONG : dp ? K_DOUBLE : K_REPEAT;
            if (evq[i].size() == 0) begin
                check($sformatf("unexpected_pulse_dut%0d", i), int'(k), int'(K_NONE));
            end else begin
                e = evq[i].pop_front();
                check($sformatf("pulse_time_dut%0d", i), cyc, e.t);
                check($sformatf("pulse_kind_dut%0d", i), int'(k), int'(e.k));
            end
        end
        if (has_busy) check($sformatf("busy_dut%0d", i), int'(bz), int'(bz_exp));
    endtask

    always @(negedge clk) begin
        bit has_b;
        bit be;
        if (running) begin
            has_b = (busy_q.size() > 0);
            be    = has_b ? busy_q.pop_front() : 1'b0;
            mon(1, sp1, lp1, dp1, rt1, bz1, has_b, be);
            mon(0, sp0, lp0, dp0, rt0, bz0, has_b, be);
        end
    end

    task automatic drive(bit lv, bit tk, bit bz);
        @(posedge clk);
        #1;
        cyc++;
        db_level = lv;
        db_tick  = tk;
        busy_q.push_back(bz);
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_short1"}, int'(sp1), 0);
        check({tag, "_long1"}, int'(lp1), 0);
        check({tag, "_double1"}, int'(dp1), 0);
        check({tag, "_repeat1"}, int'(rt1), 0);
        check({tag, "_busy1"}, int'(bz1), 0);
        check({tag, "_short0"}, int'(sp0), 0);
        check({tag, "_long0"}, int'(lp0), 0);
        check({tag, "_double0"}, int'(dp0), 0);
        check({tag, "_repeat0"}, int'(rt0), 0);
        check({tag, "_busy0"}, int'(bz0), 0);
    endtask

    // One gesture: tick at t0, level high for h1 cycles; if released early and d is
    // within the gap window, a second tick at release+d held for h2 cycles.
    // idle = IDLE cycles after the gesture ends before the next tick may come.
    task automatic gesture(int h1, int d, int h2, int idle, bit blip);
        int t0, tr, t2, bend;
        bit l, k;
        t0 = cyc + 1;
        tr = t0 + h1;
        t2 = -1;
        if (h1 >= LONG) begin
            expect_ev(t0 + LONG, K_LONG);
            for (int t = t0 + LONG + REP; t <= tr; t += REP) expect_ev(t, K_REPEAT);
            bend = tr;
        end else if (d >= 1 && d <= GAP - 1) begin
            t2 = tr + d;
            expect_ev(t2 + 1, K_DOUBLE);
            bend = t2 + h2;
        end else begin
            expect_ev(tr + GAP, K_SHORT);
            bend = tr + GAP - 1;
        end
        for (int t = t0; t <= bend + idle; t++) begin
            k = (t == t0) || (t == t2);
            l = (t < tr) || (t2 >= 0 && t >= t2 && t < t2 + h2);
            if (blip && idle >= 3 && t > bend + 1 && t < bend + idle) l = 1'b1;
            drive(l, k, (t > t0) && (t <= bend));
        end
    endtask

    // Long press abandoned by reset two cycles after long_press, level kept high.
    task automatic reset_gesture();
        int t0;
        t0 = cyc + 1;
        expect_ev(t0 + LONG, K_LONG);
        for (int t = t0; t <= t0 + LONG + 1; t++) drive(1'b1, t == t0, t > t0);
        drive(1'b1, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_quiet("midreset");
        drive(1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (6) drive(1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int typ;
        bit blip;
        reset    = 1'b1;
        db_level = 1'b0;
        db_tick  = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset   = 1'b0;
        running = 1'b1;

        gesture(3, 0, 0, 2, 1'b0);          // short press
        gesture(20, 0, 0, 2, 1'b0);         // long + repeats
        gesture(2, 3, 2, 2, 1'b0);          // double press
        gesture(3, GAP - 1, 2, 1, 1'b0);    // tick on the last gap cycle
        gesture(3, 0, 0, 0, 1'b0);          // next tick right at the short pulse
        gesture(LONG - 1, 0, 0, 2, 1'b0);   // one short of long
        gesture(LONG, 0, 0, 4, 1'b1);       // exactly long, idle blip
        reset_gesture();

        repeat (150) begin
            typ  = int'($urandom_range(0, 4));
            blip = 1'($urandom_range(0, 1));
            case (typ)
                0: gesture(int'($urandom_range(1, LONG - 1)), 0, 0, int'($urandom_range(0, 6)), blip);
                1: gesture(int'($urandom_range(LONG, LONG + 3 * REP + 2)), 0, 0, int'($urandom_range(0, 6)), blip);
                2: gesture(int'($urandom_range(1, LONG - 1)), int'($urandom_range(1, GAP - 1)),
                           int'($urandom_range(1, 12)), int'($urandom_range(0, 6)), blip);
                3: gesture(int'($urandom_range(1, LONG - 1)), 0, 0, 0, 1'b0);
                default: gesture(LONG - 1 + int'($urandom_range(0, 1)), 0, 0, int'($urandom_range(1, 4)), blip);
            endcase
        end

        repeat (12) drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        running = 1'b0;
        check("leftover_events_dut1", evq[1].size(), 0);
        check("leftover_events_dut0", evq[0].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
